// File: rtl/hack_alu_sequencer.sv
// Hack CPU control sequencer: fetches/decodes A- and C-instructions, holds A/D/PC and
// drives the external ALU and data memory. Optional halt detection: HACK_HALT_DETECT_EN.
module hack_alu_sequencer #(
    parameter int PC_W   = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   instr_addr,
    input  logic [15:0]       instr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [14:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [5:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LOAD,
        S_MREAD,
        S_EXEC,
        S_MWRITE
`ifdef HACK_HALT_DETECT_EN
        , S_HALT
`endif
    } state_t;

    // mem_req is asserted by the sequencer and held, with address/data/we stable,
    // until the cycle in which mem_ack is sampled high; it drops the cycle after.
    state_t state, state_next;

    logic [PC_W-1:0]   pc, pc_pend, pc_next;
    logic [DATA_W-1:0] a_reg, d_reg, m_latch, w_data;
    logic [15:0]       ir;
    logic [14:0]       w_addr;
    logic              dest_a, dest_d, dest_m;
    logic              jump_taken, halt_hit;

    assign dest_a = ir[5];
    assign dest_d = ir[4];
    assign dest_m = ir[3];

    assign jump_taken = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);
    assign pc_next    = jump_taken ? a_reg[PC_W-1:0] : pc + 1'b1;
    assign halt_hit   = (ir[2:0] == 3'b111) && (a_reg[PC_W-1:0] == pc);

    assign instr_addr = pc;
    assign alu_x      = d_reg;
    assign alu_y      = ir[12] ? m_latch : a_reg;
    assign mem_wdata  = w_data;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = w_addr;
        alu_op     = 6'd0;
        halted     = 1'b0;
        case (state)
            S_FETCH: state_next = S_LOAD;
            S_LOAD: begin
                if (!instr_data[15])     state_next = S_FETCH;
                else if (instr_data[12]) state_next = S_MREAD;
                else                     state_next = S_EXEC;
            end
            S_MREAD: begin
                mem_req  = 1'b1;
                mem_addr = a_reg[14:0];
                if (mem_ack) state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_op = ir[11:6];
`ifdef HACK_HALT_DETECT_EN
                if (halt_hit)    state_next = S_HALT;
                else if (dest_m) state_next = S_MWRITE;
                else             state_next = S_FETCH;
`else
                if (dest_m) state_next = S_MWRITE;
                else        state_next = S_FETCH;
`endif
            end
            S_MWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_next = S_FETCH;
            end
`ifdef HACK_HALT_DETECT_EN
            S_HALT: halted = 1'b1;
`endif
            default: state_next = S_FETCH;
        endcase
    end

    // Datapath. EXEC reads the pre-instruction A for the jump target and write address;
    // a store defers the PC update until its MWRITE completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            pc_pend <= '0;
            a_reg   <= '0;
            d_reg   <= '0;
            m_latch <= '0;
            ir      <= '0;
            w_addr  <= '0;
            w_data  <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    ir <= instr_data;
                    if (!instr_data[15]) begin
                        a_reg <= {{(DATA_W-15){1'b0}}, instr_data[14:0]};
                        pc    <= pc + 1'b1;
                    end
                end
                S_MREAD: begin
                    if (mem_ack) m_latch <= mem_rdata;
                end
                S_EXEC: begin
                    if (dest_a) a_reg <= alu_out;
                    if (dest_d) d_reg <= alu_out;
                    if (dest_m && !(halt_hit && `ifdef HACK_HALT_DETECT_EN 1'b1 `else 1'b0 `endif)) begin
                        w_addr  <= a_reg[14:0];
                        w_data  <= alu_out;
                        pc_pend <= pc_next;
                    end else begin
                        pc <= pc_next;
                    end
                end
                S_MWRITE: begin
                    if (mem_ack) pc <= pc_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_alu_sequencer.sv
// Directed bench for hack_alu_sequencer: ROM model plus hand-driven ALU and memory
// responses; exercises HACK_HALT_DETECT_EN behaviour when that macro is defined.
module tb_hack_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] instr_addr;
    logic [15:0] instr_data = 16'h0;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_op;
    logic        alu_zr, alu_ng, halted;

    logic [15:0] rom [0:127];
    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) instr_data <= rom[instr_addr[6:0]];

    assign alu_zr = (alu_out == 16'h0);
    assign alu_ng = alu_out[15];

    hack_alu_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .halted(halted)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input logic [15:0] i0, input logic [15:0] i1);
        for (int i = 0; i < 128; i++) rom[i] = 16'h0;
        rom[0] = i0;
        rom[1] = i1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    logic [15:0] outs  [3];
    logic [7:0]  taken [3];
    logic [15:0] exp_pc;

    initial begin
        outs[0]  = 16'h0000; taken[0] = 8'b1100_1100;
        outs[1]  = 16'h0001; taken[1] = 8'b1010_1010;
        outs[2]  = 16'h8000; taken[2] = 8'b1111_0000;
        alu_out = 16'h0005;

        // Reset state
        load_prog(16'h0005, 16'hEC10);
        do_reset();
        check("rst_pc", {1'b0, instr_addr}, 16'h0000);
        check("rst_req", {15'h0, mem_req}, 16'h0);
        check("rst_we", {15'h0, mem_we}, 16'h0);
        check("rst_halted", {15'h0, halted}, 16'h0);
        check("rst_d", alu_x, 16'h0000);
        check("rst_op", {10'h0, alu_op}, 16'h0);

        // A-instruction then D=A
        tick(2);
        check("ainst_a", alu_y, 16'h0005);
        check("ainst_pc", {1'b0, instr_addr}, 16'h0001);
        tick(2);
        check("dea_op", {10'h0, alu_op}, 16'h0030);
        tick(1);
        check("dea_d", alu_x, 16'h0005);
        check("dea_pc", {1'b0, instr_addr}, 16'h0002);
        check("dea_op_idle", {10'h0, alu_op}, 16'h0);

        // M read (delayed ack) then M write (delayed ack)
        load_prog(16'h0010, 16'hF008);
        alu_out = 16'h00AB;
        do_reset();
        tick(4);
        check("mr_req", {15'h0, mem_req}, 16'h1);
        check("mr_we", {15'h0, mem_we}, 16'h0);
        check("mr_addr", {1'b0, mem_addr}, 16'h0010);
        tick(3);
        check("mr_hold", {15'h0, mem_req}, 16'h1);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick(1);
        mem_ack = 1'b0; mem_rdata = 16'h0;
        check("mr_drop", {15'h0, mem_req}, 16'h0);
        check("mr_y", alu_y, 16'h1234);
        tick(1);
        check("mw_req", {15'h0, mem_req}, 16'h1);
        check("mw_we", {15'h0, mem_we}, 16'h1);
        check("mw_addr", {1'b0, mem_addr}, 16'h0010);
        check("mw_data", mem_wdata, 16'h00AB);
        tick(2);
        check("mw_pc_wait", {1'b0, instr_addr}, 16'h0001);
        check("mw_hold", {15'h0, mem_req}, 16'h1);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        check("mw_drop", {15'h0, mem_req}, 16'h0);
        check("mw_pc", {1'b0, instr_addr}, 16'h0002);

        // Reset during MREAD with an ack in and after the reset cycle
        do_reset();
        tick(4);
        check("rr_req_pre", {15'h0, mem_req}, 16'h1);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick(1);
        rst = 1'b0;
        check("rr_req", {15'h0, mem_req}, 16'h0);
        check("rr_pc", {1'b0, instr_addr}, 16'h0000);
        tick(1);
        mem_ack = 1'b0; mem_rdata = 16'h0;
        check("rr_d", alu_x, 16'h0000);
        check("rr_m", dut.m_latch, 16'h0000);
        tick(1);
        check("rr_refetch_a", alu_y, 16'h0010);

        // Jump sweep, A=0x0040
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) begin
                load_prog(16'h0040, 16'hE000 | 16'(j));
                alu_out = outs[k];
                do_reset();
                tick(5);
                exp_pc = taken[k][j] ? 16'h0040 : 16'h0002;
                check($sformatf("jmp_j%0d_k%0d", j, k), {1'b0, instr_addr}, exp_pc);
            end
        end

        // AM=comp;JMP with A=0x0020: write to old A, jump to old A, A updated
        load_prog(16'h0020, 16'hE02F);
        alu_out = 16'h0099;
        do_reset();
        tick(5);
        check("am_addr", {1'b0, mem_addr}, 16'h0020);
        check("am_data", mem_wdata, 16'h0099);
        check("am_we", {15'h0, mem_we}, 16'h1);
        mem_ack = 1'b1;
        tick(1);
        mem_ack = 1'b0;
        check("am_a", alu_y, 16'h0099);
        check("am_pc", {1'b0, instr_addr}, 16'h0020);

`ifdef HACK_HALT_DETECT_EN
        load_prog(16'h0007, 16'hE007);
        rom[7] = 16'hE007;
        alu_out = 16'h0000;
        do_reset();
        tick(8);
        check("halt_set", {15'h0, halted}, 16'h1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("halt_req", {15'h0, mem_req}, 16'h0);
            check("halt_pc", {1'b0, instr_addr}, 16'h0007);
        end
        do_reset();
        check("halt_clr", {15'h0, halted}, 16'h0);
`else
        check("no_halt", {15'h0, halted}, 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
